// File: rtl/a23_run_ctrl_if.sv
// Load/drain stream bundle for the a23 run controller.
// The controller uses the slave modport; whoever feeds images and drains results uses master.
interface a23_run_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/a23_run_ctrl.sv
// Run controller for a23_gc_main: streams in code/g/e images, runs the core, counts cycles, drains outputs.
// Define A23_RUN_TIMEOUT_EN to build the max_cc timeout comparator and the timeout flag.
module a23_run_ctrl #(
    parameter int DATA_W        = 32,
    parameter int CODE_MEM_SIZE = 64,
    parameter int G_MEM_SIZE    = 64,
    parameter int E_MEM_SIZE    = 64,
    parameter int OUT_MEM_SIZE  = 64,
    parameter int CC_W          = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CC_W-1:0]                 max_cc,
    a23_run_ctrl_if.slave                   stream,
    output logic [CODE_MEM_SIZE*DATA_W-1:0] p_init,
    output logic [G_MEM_SIZE*DATA_W-1:0]    g_init,
    output logic [E_MEM_SIZE*DATA_W-1:0]    e_init,
    output logic                            core_rst,
    input  logic [OUT_MEM_SIZE*DATA_W-1:0]  o,
    input  logic                            terminate,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic [CC_W-1:0]                 cc
);
    localparam int MAX_A  = (CODE_MEM_SIZE > G_MEM_SIZE) ? CODE_MEM_SIZE : G_MEM_SIZE;
    localparam int MAX_B  = (E_MEM_SIZE > OUT_MEM_SIZE) ? E_MEM_SIZE : OUT_MEM_SIZE;
    localparam int MAX_SZ = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IDX_W  = (MAX_SZ > 1) ? $clog2(MAX_SZ) : 1;

    localparam logic [IDX_W-1:0] P_LAST = IDX_W'(CODE_MEM_SIZE - 1);
    localparam logic [IDX_W-1:0] G_LAST = IDX_W'(G_MEM_SIZE - 1);
    localparam logic [IDX_W-1:0] E_LAST = IDX_W'(E_MEM_SIZE - 1);
    localparam logic [IDX_W-1:0] O_LAST = IDX_W'(OUT_MEM_SIZE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_P = 3'd1;
    localparam logic [2:0] S_LOAD_G = 3'd2;
    localparam logic [2:0] S_LOAD_E = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]                       state_r;
    logic [2:0]                       state_nx_s;
    logic [IDX_W-1:0]                 idx_r;
    logic [IDX_W-1:0]                 idx_inc_s;
    logic [IDX_W-1:0]                 last_idx_s;
    logic                             idx_last_s;
    logic                             in_xfer_s;
    logic                             out_xfer_s;
    logic                             start_s;
    logic                             cc_at_max_s;
    logic                             run_exit_s;
    logic [CODE_MEM_SIZE*DATA_W-1:0]  p_r;
    logic [G_MEM_SIZE*DATA_W-1:0]     g_r;
    logic [E_MEM_SIZE*DATA_W-1:0]     e_r;
    logic [OUT_MEM_SIZE*DATA_W-1:0]   shadow_r;
    logic [DATA_W-1:0]                out_data_r;
    logic [CC_W-1:0]                  cc_r;
    logic                             in_ready_r;
    logic                             out_valid_r;
    logic                             busy_r;
    logic                             done_r;
    logic                             core_rst_r;

    assign in_xfer_s  = in_ready_r & stream.in_valid;
    assign out_xfer_s = out_valid_r & stream.out_ready;
    assign start_s    = start & ((state_r == S_IDLE) | (state_r == S_DONE));
    assign idx_inc_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    assign idx_last_s = (idx_r == last_idx_s);

`ifdef A23_RUN_TIMEOUT_EN
    assign cc_at_max_s = (max_cc != {CC_W{1'b0}}) && (cc_r == max_cc);
`else
    logic unused_max_cc_s;
    assign unused_max_cc_s = ^max_cc;
    assign cc_at_max_s     = 1'b0;
`endif

    assign run_exit_s = (state_r == S_RUN) & (terminate | cc_at_max_s);

    // Last valid word index of whichever image the current state walks through
    always_comb begin
        last_idx_s = {IDX_W{1'b0}};
        case (state_r)
            S_LOAD_P: last_idx_s = P_LAST;
            S_LOAD_G: last_idx_s = G_LAST;
            S_LOAD_E: last_idx_s = E_LAST;
            S_DRAIN:  last_idx_s = O_LAST;
            default:  last_idx_s = {IDX_W{1'b0}};
        endcase
    end

    // Next-state logic for the job sequence
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) state_nx_s = S_LOAD_P;
                else       state_nx_s = state_r;
            end
            S_LOAD_P: begin
                if (in_xfer_s && idx_last_s) state_nx_s = S_LOAD_G;
                else                         state_nx_s = state_r;
            end
            S_LOAD_G: begin
                if (in_xfer_s && idx_last_s) state_nx_s = S_LOAD_E;
                else                         state_nx_s = state_r;
            end
            S_LOAD_E: begin
                if (in_xfer_s && idx_last_s) state_nx_s = S_RUN;
                else                         state_nx_s = state_r;
            end
            S_RUN: begin
                if (run_exit_s) state_nx_s = S_DRAIN;
                else            state_nx_s = state_r;
            end
            S_DRAIN: begin
                if (out_xfer_s && idx_last_s) state_nx_s = S_DONE;
                else                          state_nx_s = state_r;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register and word index; every state change restarts the index at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (state_nx_s != state_r)        idx_r <= {IDX_W{1'b0}};
            else if (in_xfer_s || out_xfer_s) idx_r <= idx_inc_s;
            else                              idx_r <= idx_r;
        end
    end

    // Handshake and status flags are decoded from the next state so they leave as flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            core_rst_r  <= 1'b1;
        end else begin
            in_ready_r  <= (state_nx_s == S_LOAD_P) | (state_nx_s == S_LOAD_G) |
                           (state_nx_s == S_LOAD_E);
            out_valid_r <= (state_nx_s == S_DRAIN);
            busy_r      <= (state_nx_s != S_IDLE) & (state_nx_s != S_DONE);
            done_r      <= (state_nx_s == S_DONE);
            core_rst_r  <= (state_nx_s != S_RUN);
        end
    end

    // Load-stream writes into the image selected by the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0;
            g_r <= '0;
            e_r <= '0;
        end else if (in_xfer_s) begin
            case (state_r)
                S_LOAD_P: p_r[idx_r*DATA_W +: DATA_W] <= stream.in_data;
                S_LOAD_G: g_r[idx_r*DATA_W +: DATA_W] <= stream.in_data;
                S_LOAD_E: e_r[idx_r*DATA_W +: DATA_W] <= stream.in_data;
                default: begin
                    p_r <= p_r;
                end
            endcase
        end else begin
            p_r <= p_r;
        end
    end

    // Output shadow capture and drain word; out_data is preloaded with word 0 on RUN exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r   <= '0;
            out_data_r <= {DATA_W{1'b0}};
        end else if (run_exit_s) begin
            shadow_r   <= o;
            out_data_r <= o[DATA_W-1:0];
        end else if (out_xfer_s && !idx_last_s) begin
            out_data_r <= shadow_r[idx_inc_s*DATA_W +: DATA_W];
        end else begin
            out_data_r <= out_data_r;
        end
    end

    // Cycle counter: counts non-terminating RUN cycles, holds on exit, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_r <= {CC_W{1'b0}};
        end else if (start_s) begin
            cc_r <= {CC_W{1'b0}};
        end else if ((state_r == S_RUN) && !run_exit_s && (cc_r != {CC_W{1'b1}})) begin
            cc_r <= cc_r + {{(CC_W-1){1'b0}}, 1'b1};
        end else begin
            cc_r <= cc_r;
        end
    end

`ifdef A23_RUN_TIMEOUT_EN
    logic timeout_r;

    // Timeout flag is set only when the limit is hit without a simultaneous terminate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (start_s) begin
            timeout_r <= 1'b0;
        end else if ((state_r == S_RUN) && !terminate && cc_at_max_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign stream.in_ready  = in_ready_r;
    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign p_init           = p_r;
    assign g_init           = g_r;
    assign e_init           = e_r;
    assign core_rst         = core_rst_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign cc               = cc_r;
endmodule
